video_st_sink: RTL and testbench



---
 rtl/video_st_sink.sv | 149 ++++++++++++++
 tb/tb_video_st_sink.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_st_sink.sv
`default_nettype none
// ============================================================================
// Module   : video_st_sink
// Purpose  : Avalon-ST video sink; packs 30-bit pixels to 12 bits and writes
//            them to a frame-buffer port, flagging short/long packets.
//            Define VIDEO_ST_SINK_GRAY_EN to write 4-bit luma on all channels.
// Revision : 1.0 - initial release
// ============================================================================
module video_st_sink #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       snk_data,
  input  logic              snk_valid,
  input  logic              snk_startofpacket,
  input  logic              snk_endofpacket,
  output logic              snk_ready,
  input  logic              stall,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       frame_count
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_xfer;
  logic [11:0]       w_pix;
  logic              w_unused;

  assign snk_ready = ~stall & ~reset;
  assign w_xfer    = snk_valid & snk_ready;

`ifdef VIDEO_ST_SINK_GRAY_EN
  logic [17:0] w_luma;
  logic [9:0]  w_y;
  assign w_luma = 18'(snk_data[29:20]) * 18'd77
                + 18'(snk_data[19:10]) * 18'd150
                + 18'(snk_data[9:0])   * 18'd29;
  assign w_y      = w_luma[17:8];
  assign w_pix    = {w_y[9:6], w_y[9:6], w_y[9:6]};
  assign w_unused = &{1'b0, w_luma[7:0], w_y[5:0]};
`else
  assign w_pix    = {snk_data[29:26], snk_data[19:16], snk_data[9:6]};
  assign w_unused = &{1'b0, snk_data[25:20], snk_data[15:10], snk_data[5:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          S_IDLE, S_DRAIN: begin
            if (snk_startofpacket) begin
              wr_en    <= 1'b1;
              wr_addr  <= '0;
              wr_data  <= w_pix;
              err_long <= (r_state == S_DRAIN);
              if (TOTAL == 1 && snk_endofpacket) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                r_cnt       <= '0;
                r_state     <= S_IDLE;
              end else begin
                r_cnt   <= c_ONE;
                r_state <= S_ACTIVE;
              end
            end else if (snk_endofpacket && r_state == S_DRAIN) begin
              err_long <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_IDLE;
            end
          end
          S_ACTIVE: begin
            wr_en   <= 1'b1;
            wr_data <= w_pix;
            if (snk_startofpacket) begin
              // Restart: a concurrent eop closes a one-pixel packet.
              err_short <= 1'b1;
              wr_addr   <= '0;
              if (snk_endofpacket) begin
                if (TOTAL == 1) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                end
                r_cnt   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_cnt <= c_ONE;
              end
            end else if (snk_endofpacket) begin
              wr_addr <= r_cnt;
              if (r_cnt == c_LAST) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
              end else begin
                err_short <= 1'b1;
              end
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              wr_addr <= r_cnt;
              if (r_cnt == c_LAST) begin
                r_state <= S_DRAIN;
              end else begin
                r_cnt <= r_cnt + c_ONE;
              end
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_st_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_st_sink
// Purpose  : Self-checking bench for video_st_sink (WIDTH=4, HEIGHT=2) with a
//            packet-level reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_st_sink;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int ADDR_W = 3;
  localparam int TOTAL  = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [29:0]       snk_data = '0;
  logic              snk_valid = 1'b0;
  logic              snk_startofpacket = 1'b0;
  logic              snk_endofpacket = 1'b0;
  logic              snk_ready;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              wr_en;
  logic              frame_done;
  logic              err_short;
  logic              err_long;
  logic [15:0]       frame_count;

  video_st_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .snk_data          (snk_data),
    .snk_valid         (snk_valid),
    .snk_startofpacket (snk_startofpacket),
    .snk_endofpacket   (snk_endofpacket),
    .snk_ready         (snk_ready),
    .stall             (stall),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_en             (wr_en),
    .frame_done        (frame_done),
    .err_short         (err_short),
    .err_long          (err_long),
    .frame_count       (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Packet-level reference model: whether a packet is open and how many beats it has seen.
  bit          m_in_pkt = 1'b0;
  int          m_pos    = 0;
  logic [15:0] m_count  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] pack(input logic [29:0] d);
    int r, g, b;
    logic [9:0] y;
    r = int'(d[29:20]);
    g = int'(d[19:10]);
    b = int'(d[9:0]);
`ifdef VIDEO_ST_SINK_GRAY_EN
    y = 10'((r * 77 + g * 150 + b * 29) / 256);
    return {y[9:6], y[9:6], y[9:6]};
`else
    y = '0;
    return {4'(r / 64), 4'(g / 64), 4'(b / 64)} | {2'b00, y};
`endif
  endfunction

  task automatic model_reset();
    m_in_pkt = 1'b0;
    m_pos    = 0;
    m_count  = '0;
  endtask

  // One clock cycle: drive inputs, predict, let the edge happen, compare.
  task automatic send(input bit v, input bit s, input bit e, input logic [29:0] d, input bit st);
    bit xf;
    int idx;
    bit we, dn, sh, lg;
    int exp_addr;
    logic [11:0] exp_data;
    we = 0; dn = 0; sh = 0; lg = 0; exp_addr = 0; exp_data = '0;
    snk_valid = v; snk_startofpacket = s; snk_endofpacket = e; snk_data = d; stall = st;
    #1;
    check_eq("snk_ready", 32'(snk_ready), 32'(!st));
    xf = v && !st;
    if (xf) begin
      if (s) begin
        sh = m_in_pkt && (m_pos < TOTAL);
        lg = m_in_pkt && (m_pos >= TOTAL);
        m_in_pkt = 1'b1;
        m_pos    = 0;
      end
      if (m_in_pkt) begin
        idx = m_pos;
        if (m_pos <= TOTAL) m_pos++;
        if (idx < TOTAL) begin
          we       = 1;
          exp_addr = (idx / WIDTH) * WIDTH + (idx % WIDTH);
          exp_data = pack(d);
        end
        if (e) begin
          if (idx == TOTAL - 1) begin
            dn = 1;
            m_count++;
          end else if (idx < TOTAL - 1) sh = 1;
          else lg = 1;
          m_in_pkt = 1'b0;
          m_pos    = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("wr_en", 32'(wr_en), 32'(we));
    if (we) begin
      check_eq("wr_addr", 32'(wr_addr), 32'(exp_addr));
      check_eq("wr_data", 32'(wr_data), 32'(exp_data));
    end
    check_eq("frame_done", 32'(frame_done), 32'(dn));
    check_eq("err_short", 32'(err_short), 32'(sh));
    check_eq("err_long", 32'(err_long), 32'(lg));
    check_eq("frame_count", 32'(frame_count), 32'(m_count));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(snk_ready), 32'd0);
    check_eq({tag, "_outs"}, 32'({wr_addr, wr_data, wr_en, frame_done, err_short, err_long}), 32'd0);
    check_eq({tag, "_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic idle_cycle();
    send(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
  endtask

  initial begin
    logic [29:0] d;
    int len;
    bit drop_eop;

    // Reset state.
    #12;
    check_reset_outputs("reset_init");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Full frame of white pixels.
    for (int i = 0; i < TOTAL; i++)
      send(1'b1, i == 0, i == TOTAL - 1, 30'h3FFF_FFFF, 1'b0);
    check_eq("white_data", 32'(wr_data), 32'hFFF);
    check_eq("frame1_count", 32'(frame_count), 32'd1);
    idle_cycle();

    // Short packet: 5 beats.
    for (int i = 0; i < 5; i++)
      send(1'b1, i == 0, i == 4, 30'($urandom), 1'b0);
    check_eq("short_count", 32'(frame_count), 32'd1);
    send(1'b1, 1'b0, 1'b1, 30'h155, 1'b0);

    // Long packet: 10 beats.
    for (int i = 0; i < 10; i++)
      send(1'b1, i == 0, i == 9, 30'($urandom), 1'b0);
    send(1'b1, 1'b0, 1'b0, 30'h2AA, 1'b0);

    // Stall three cycles after beat 3.
    for (int i = 0; i < 4; i++) send(1'b1, i == 0, 1'b0, 30'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0, 30'($urandom), 1'b1);
    for (int i = 4; i < TOTAL; i++) send(1'b1, 1'b0, i == TOTAL - 1, 30'($urandom), 1'b0);
    check_eq("stall_count", 32'(frame_count), 32'd2);

    // Reset after beat 5, then a full frame.
    for (int i = 0; i < 6; i++) send(1'b1, i == 0, 1'b0, 30'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < TOTAL; i++)
      send(1'b1, i == 0, i == TOTAL - 1, 30'($urandom), 1'b0);
    check_eq("post_reset_count", 32'(frame_count), 32'd1);

    // Restart with sop+eop while a packet is open.
    for (int i = 0; i < 3; i++) send(1'b1, i == 0, 1'b0, 30'($urandom), 1'b0);
    send(1'b1, 1'b1, 1'b1, 30'($urandom), 1'b0);
    send(1'b1, 1'b0, 1'b0, 30'($urandom), 1'b0);

    // Single red pixel.
    send(1'b1, 1'b1, 1'b0, {10'h3FF, 10'h000, 10'h000}, 1'b0);
`ifdef VIDEO_ST_SINK_GRAY_EN
    check_eq("red_pixel", 32'(wr_data), 32'h444);
`else
    check_eq("red_pixel", 32'(wr_data), 32'hF00);
`endif
    send(1'b1, 1'b0, 1'b1, 30'h0, 1'b0);

    // Randomized packets around the nominal length, with gaps, stalls and strays.
    for (int p = 0; p < 60; p++) begin
      len      = TOTAL - 2 + int'($urandom_range(0, 4));
      drop_eop = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) send(1'b1, 1'b0, $urandom_range(0, 1) == 1, 30'($urandom), 1'b0);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 4) == 0)
          send($urandom_range(0, 1) == 1, 1'b0, 1'b0, 30'($urandom), $urandom_range(0, 1) == 1);
        d = 30'($urandom);
        send(1'b1, i == 0, (i == len - 1) && !drop_eop, d, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
